// File: rtl/pwm_fade_controller.sv
// Breathing-fade sequencer for one PWM channel: ramps duty up, holds, ramps down, holds,
// changing duty/max_value only on PWM period boundaries and fading out cleanly on disable.
module pwm_fade_controller #(
    parameter int BIT_WIDTH = 3,
    parameter int STEP_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [BIT_WIDTH-1:0] max_cfg,
    input  logic [STEP_W-1:0]    step_periods,
    input  logic [STEP_W-1:0]    hold_periods,
    output logic [BIT_WIDTH-1:0] duty,
    output logic [BIT_WIDTH-1:0] max_value,
    output logic                 period_end,
    output logic                 busy,
    output logic [2:0]           state,
    output logic                 cycle_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    state_t             st;
    logic [BIT_WIDTH:0] pcnt;
    logic [STEP_W-1:0]  step_cnt;
    logic [STEP_W-1:0]  hold_cnt;
    logic [STEP_W-1:0]  step_lim;
    logic [STEP_W-1:0]  hold_lim;
    logic [STEP_W:0]    step_next;
    logic [STEP_W:0]    hold_next;
    logic               step_evt;
    logic               hold_evt;

    // A programmed count of zero behaves as one period.
    assign step_lim  = (step_periods == '0) ? STEP_W'(1) : step_periods;
    assign hold_lim  = (hold_periods == '0) ? STEP_W'(1) : hold_periods;
    assign step_next = {1'b0, step_cnt} + (STEP_W+1)'(1);
    assign hold_next = {1'b0, hold_cnt} + (STEP_W+1)'(1);

    assign period_end = (pcnt == {1'b0, max_value}) && (st != IDLE);
    assign step_evt   = period_end && (step_next >= {1'b0, step_lim});
    assign hold_evt   = period_end && (hold_next >= {1'b0, hold_lim});
    assign busy       = (st != IDLE);
    assign state      = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            duty       <= '0;
            max_value  <= '0;
            cycle_done <= 1'b0;
            pcnt       <= '0;
            step_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            // NOTE: every register here uses <= so all next-state terms see the pre-edge values.
            cycle_done <= 1'b0;

            if (st == IDLE || period_end)
                pcnt <= '0;
            else
                pcnt <= pcnt + (BIT_WIDTH+1)'(1);

            case (st)
                IDLE: begin
                    duty     <= '0;
                    step_cnt <= '0;
                    hold_cnt <= '0;
                    if (enable) begin
                        st        <= RAMP_UP;
                        max_value <= max_cfg;
                    end
                end

                RAMP_UP: begin
                    if (period_end) begin
                        // A dropped enable takes priority over a coincident step.
                        if (!enable) begin
                            st       <= RAMP_DOWN;
                            step_cnt <= '0;
                            hold_cnt <= '0;
                        end else if (step_evt) begin
                            step_cnt <= '0;
                            hold_cnt <= '0;
                            if (duty == max_value)
                                st <= HOLD_HIGH;
                            else
                                duty <= duty + BIT_WIDTH'(1);
                        end else begin
                            step_cnt <= step_next[STEP_W-1:0];
                        end
                    end
                end

                HOLD_HIGH: begin
                    if (period_end) begin
                        if (!enable || hold_evt) begin
                            st       <= RAMP_DOWN;
                            step_cnt <= '0;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_next[STEP_W-1:0];
                        end
                    end
                end

                RAMP_DOWN: begin
                    if (step_evt) begin
                        step_cnt <= '0;
                        hold_cnt <= '0;
                        if (duty == '0)
                            st <= HOLD_LOW;
                        else
                            duty <= duty - BIT_WIDTH'(1);
                    end else if (period_end) begin
                        step_cnt <= step_next[STEP_W-1:0];
                    end
                end

                HOLD_LOW: begin
                    if (hold_evt) begin
                        cycle_done <= 1'b1;
                        step_cnt   <= '0;
                        hold_cnt   <= '0;
                        if (enable) begin
                            st        <= RAMP_UP;
                            max_value <= max_cfg;
                        end else begin
                            st <= IDLE;
                        end
                    end else if (period_end) begin
                        hold_cnt <= hold_next[STEP_W-1:0];
                    end
                end

                default: begin
                    st       <= IDLE;
                    duty     <= '0;
                    step_cnt <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_fade_controller.md
Name: pwm_fade_controller

Overview:
Sequencer that drives the duty and max_value configuration inputs of one PWM channel to produce a repeating "breathing" fade: ramp up, hold high, ramp down, hold low.
- Keeps an internal period counter matched to the PWM period (max_value+1 clocks).
- Changes duty only at period boundaries.
- Handles graceful fade-out when disabled.
- Sits between the VGA/GPU control registers and each pwm_module instance.

Parameters:
BIT_WIDTH, 3, width of duty/max_value buses (matches PWM channel)
STEP_W, 8, width of step_periods / hold_periods counters

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
enable  input  1  level; high = run fade cycles, low = fade out then idle
max_cfg  input  BIT_WIDTH  requested PWM max_value, sampled at cycle start
step_periods  input  STEP_W  PWM periods per duty level (0 treated as 1)
hold_periods  input  STEP_W  PWM periods per hold phase (0 treated as 1)
duty  output  BIT_WIDTH  registered duty to PWM channel
max_value  output  BIT_WIDTH  registered max_value to PWM channel
period_end  output  1  high on last clock of each PWM period while not IDLE
busy  output  1  high whenever state != IDLE
state  output  3  IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4, others unused
cycle_done  output  1  registered one-clock pulse when HOLD_LOW completes

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, duty=0, max_value=0, cycle_done=0.
  - pcnt=0, step/hold counters=0.
  - Applies mid-operation too, overriding all other activity.
- Period counter pcnt:
  - BIT_WIDTH+1 bits; held 0 in IDLE.
  - Otherwise increments each clk and wraps to 0 when pcnt==max_value.
  - period_end = (pcnt==max_value) && state!=IDLE.
- Step event: on period_end when step count reaches max(step_periods,1). The step counter then clears.
- Hold done: on period_end when hold count reaches max(hold_periods,1). The hold counter then clears.
- Counters clear on every state transition. step_periods/hold_periods are sampled live.
- IDLE:
  - duty=0.
  - If enable=1 at a posedge: next state RAMP_UP, max_value<=max_cfg, duty<=0, pcnt<=0.
- RAMP_UP: on step event, if duty==max_value go HOLD_HIGH (duty unchanged), else duty<=duty+1.
- HOLD_HIGH: on hold done go RAMP_DOWN.
- RAMP_DOWN: on step event, if duty==0 go HOLD_LOW, else duty<=duty-1.
- HOLD_LOW: on hold done, cycle_done<=1 for one clk.
  - If enable=1: go RAMP_UP and reload max_value<=max_cfg.
  - Else: go IDLE.
- enable deasserted in RAMP_UP or HOLD_HIGH:
  - At the next period_end, go RAMP_DOWN. Duty is unchanged and counters clear.
  - The fade then completes normally to HOLD_LOW, then IDLE.
- enable deasserted in RAMP_DOWN/HOLD_LOW: no effect until HOLD_LOW exit.
- Simultaneous step event and enable drop in RAMP_UP: the enable drop wins, so the state goes RAMP_DOWN with duty unchanged.
- max_value==0: period is 1 clk, duty stays 0, and RAMP_UP exits on its first step event.
- Duty and max_value never change except at a period_end or an IDLE exit. There is no wrap of duty: it is bounded to [0, max_value].
- max_cfg changes mid-cycle are ignored until the next cycle start.

Test Plan:
- Reset check: rst_n=0 for 2 clk with enable=1 -> duty=0, max_value=0, state=0, busy=0, cycle_done=0, period_end=0.
- Basic cycle: BIT_WIDTH=3, max_cfg=3, step=1, hold=2, enable=1 from IDLE.
  - duty follows 0,1,2,3 (4 clk each), held at 3 for 8 clk, then 3,2,1,0 (4 clk each), then 0 for 8 clk.
  - cycle_done pulses once, 48 clk after RAMP_UP entry, and state returns to RAMP_UP.
- Zero counts: step=0, hold=0, max_cfg=1 -> behaves as step=1, hold=1; duty 0,1 (2 clk each), hold 2 clk, 1,0 (2 clk each), hold 2 clk; cycle 12 clk.
- Graceful stop: drop enable while state=RAMP_UP with duty=2 (max_cfg=7, step=1).
  - At next period_end -> RAMP_DOWN, duty 2,1,0, then HOLD_LOW, then IDLE.
  - cycle_done pulses once; busy falls on the same edge as the IDLE entry.
- Config latch: change max_cfg 3->7 during HOLD_HIGH -> max_value stays 3 until the HOLD_LOW exit edge, then 7; period_end spacing goes 4->8 clk.
- Reset mid-operation: assert rst_n=0 during RAMP_DOWN with duty=5 -> next edge duty=0, state=IDLE. After release with enable=1, the cycle restarts at duty 0.
